// File: rtl/truth_seq_pkg.sv
// Shared definitions for the truth-table sequencer: FSM state encoding,
// settle counter width and the row-count derivation.
package truth_seq_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Number of truth-table rows for a gate with n_in inputs.
  function automatic int rows_of(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Settle timer: counts enabled cycles and flags the cycle on which the
// SETTLE-th consecutive enabled cycle is reached.
module settle_timer
  import truth_seq_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  // Cycle counter; cleared between vectors, advances only while enabled.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Current cycle is the SETTLE-th one when the count already holds SETTLE-1.
  assign expired = enable && (count == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: walks a combinational gate through every input
// vector, samples its output after a settle time and scores it against a
// latched expected table.
module truth_table_sequencer
  import truth_seq_pkg::*;
#(
  parameter  int N_IN   = 2,
  parameter  int SETTLE = 1,
  localparam int ROWS   = rows_of(N_IN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [ROWS-1:0] expected,
  output logic [N_IN-1:0] gate_in,
  input  logic            gate_out,
  output logic            busy,
  output logic            done,
  output logic [ROWS-1:0] result,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_bad_idx,
  output logic            first_bad_valid
);

  state_t          state;
  logic [N_IN-1:0] idx;
  logic [ROWS-1:0] exp_latched;
  logic            settle_done;
  logic            timer_clear;
  logic            mismatch;
  logic [N_IN:0]   err_next;

  // Counter restarts for every vector: cleared while idle and while sampling.
  assign timer_clear = (state == IDLE) || (state == SAMPLE);

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (state == APPLY),
    .expired (settle_done)
  );

  // Scoring of the row currently being sampled; the count includes this row.
  assign mismatch = (gate_out != exp_latched[idx]);
  assign err_next = err_count + (N_IN + 1)'(mismatch);

  // Outputs decoded from state or taken straight from registers.
  assign gate_in = idx;
  assign busy    = (state != IDLE);
  assign done    = (state == FINISH);

  // Sequencer FSM and scoreboard.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      idx             <= '0;
      exp_latched     <= '0;
      result          <= '0;
      err_count       <= '0;
      first_bad_idx   <= '0;
      first_bad_valid <= 1'b0;
      pass            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            exp_latched     <= expected;
            result          <= '0;
            err_count       <= '0;
            first_bad_idx   <= '0;
            first_bad_valid <= 1'b0;
            pass            <= 1'b0;
            idx             <= '0;
            state           <= APPLY;
          end
        end
        APPLY: begin
          if (settle_done) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          result[idx] <= gate_out;
          err_count   <= err_next;
          if (mismatch && !first_bad_valid) begin
            first_bad_idx   <= idx;
            first_bad_valid <= 1'b1;
          end
          if (idx == N_IN'(ROWS - 1)) begin
            // Verdict is ready in the same cycle done is shown.
            pass  <= (err_next == '0);
            idx   <= '0;
            state <= FINISH;
          end else begin
            idx   <= idx + 1'b1;
            state <= APPLY;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
